// File: rtl/conta_m5_ctrl_pkg.sv
// Shared state encoding for the modulo-counter sequencer family.
package conta_m5_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSA = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/conta_m5_ctrl_conta_up_mod_ear.sv
// Modulo-N up counter with async reset, synchronous clear, enable and terminal-count flag.
module conta_up_mod_ear #(
  parameter int MODULO  = 5,
  parameter int ANCHO_Q = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  output logic [ANCHO_Q-1:0] q,
  output logic               tc
);

  localparam logic [ANCHO_Q-1:0] Q_MAX = ANCHO_Q'(MODULO - 1);

  assign tc = en && (q == Q_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= (q == Q_MAX) ? '0 : q + ANCHO_Q'(1);
    end
  end

endmodule

// File: rtl/conta_m5_ctrl.sv
// Sequencer that runs the modulo counter for a programmed number of complete turns,
// with pause/resume and abort; sole driver of the counter enable.
module conta_m5_ctrl
  import conta_m5_ctrl_pkg::*;
#(
  parameter int MODULO  = 5,
  parameter int ANCHO_Q = 3,
  parameter int ANCHO_N = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic [ANCHO_N-1:0] n_vueltas,
  output logic [ANCHO_Q-1:0] q,
  output logic [ANCHO_N-1:0] vueltas,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [ANCHO_N-1:0] n_reg;
  logic [ANCHO_N-1:0] vueltas_inc;
  logic               cnt_en;
  logic               cnt_clr;
  logic               tc;

  assign vueltas_inc = vueltas + ANCHO_N'(1);
  assign cnt_en      = (state == RUN) && !stop && !pause;
  // q is zeroed when a run is launched and when a run is aborted.
  assign cnt_clr     = ((state == IDLE) && start) ||
                       (((state == RUN) || (state == PAUSA)) && stop);

  conta_up_mod_ear #(
    .MODULO (MODULO),
    .ANCHO_Q(ANCHO_Q)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clr),
    .en   (cnt_en),
    .q    (q),
    .tc   (tc)
  );

  // busy/done are registered alongside the state so they always mirror it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      n_reg   <= '0;
      vueltas <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vueltas <= '0;
            n_reg   <= n_vueltas;
            if (n_vueltas != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            vueltas <= '0;
            busy    <= 1'b0;
          end else if (pause) begin
            state <= PAUSA;
          end else if (tc) begin
            vueltas <= vueltas_inc;
            if (vueltas_inc == n_reg) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        PAUSA: begin
          if (stop) begin
            state   <= IDLE;
            vueltas <= '0;
            busy    <= 1'b0;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
